// File: rtl/lsu_laq_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_laq_fifo_if
//  Purpose  : Handshake/bus bundle for the LSU load address queue. It carries
//             the core request channel, the memory request channel, the memory
//             response channel, the core result channel and the empty flag.
//  Modports : slave  - the load queue itself (accepts core requests, drives
//                      memory requests and core results)
//             master - the surrounding environment (core + memory)
//  Ports    : lsu_q*  core load request   (valid/ready/tag/signed/addr/size)
//             mem_q*  memory request      (valid/ready/addr)
//             mem_p*  memory response     (valid/ready/data)
//             lsu_p*  core load result    (valid/ready/tag/data)
//             empty_o no loads outstanding
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_laq_fifo_if #(
  parameter int TAG_W = 5
);
  logic             lsu_qvalid_i;
  logic             lsu_qready_o;
  logic [TAG_W-1:0] lsu_qtag_i;
  logic             lsu_qsigned_i;
  logic [31:0]      lsu_qaddr_i;
  logic [1:0]       lsu_qsize_i;
  logic             mem_qvalid_o;
  logic             mem_qready_i;
  logic [31:0]      mem_qaddr_o;
  logic             mem_pvalid_i;
  logic             mem_pready_o;
  logic [63:0]      mem_pdata_i;
  logic             lsu_pvalid_o;
  logic             lsu_pready_i;
  logic [TAG_W-1:0] lsu_ptag_o;
  logic [63:0]      lsu_pdata_o;
  logic             empty_o;

  modport slave (
    input  lsu_qvalid_i, lsu_qtag_i, lsu_qsigned_i, lsu_qaddr_i, lsu_qsize_i,
    input  mem_qready_i, mem_pvalid_i, mem_pdata_i, lsu_pready_i,
    output lsu_qready_o, mem_qvalid_o, mem_qaddr_o, mem_pready_o,
    output lsu_pvalid_o, lsu_ptag_o, lsu_pdata_o, empty_o
  );

  modport master (
    output lsu_qvalid_i, lsu_qtag_i, lsu_qsigned_i, lsu_qaddr_i, lsu_qsize_i,
    output mem_qready_i, mem_pvalid_i, mem_pdata_i, lsu_pready_i,
    input  lsu_qready_o, mem_qvalid_o, mem_qaddr_o, mem_pready_o,
    input  lsu_pvalid_o, lsu_ptag_o, lsu_pdata_o, empty_o
  );
endinterface
`default_nettype wire

// File: rtl/lsu_laq_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_laq_fifo
//  Purpose  : Load address queue plus response aligner for the LSU load path.
//             Requests pass straight through to memory as 64-bit aligned
//             accesses while their tag/sign/offset/size is queued in order.
//             Each in-order memory response pops the oldest entry, the
//             addressed bytes are extracted and sign/zero-extended, and the
//             {tag, data} result is held in a 1-deep registered output slot.
//  Ports    : clk_i   clock
//             rst_ni  asynchronous active-low reset
//             bus     lsu_laq_fifo_if.slave (request, memory, result channels)
//  Params   : DEPTH   queue entries, power of two, >= 2
//             tag_t   load tag type
//  Revision : 1.0  initial release
// ============================================================================
module lsu_laq_fifo #(
  parameter int  DEPTH = 4,
  parameter type tag_t = logic [4:0]
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  lsu_laq_fifo_if.slave      bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    tag_t       tag;
    logic       sign_ext;
    logic [2:0] offset;
    logic [1:0] size;
  } laq_t;

  laq_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_pvalid;
  tag_t             r_ptag;
  logic [63:0]      r_pdata;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_pready;
  laq_t             w_head;
  logic [63:0]      w_sh;
  logic             w_fill;
  logic [63:0]      w_aligned;

  // Full/empty come from the registered count only, so a pop in this cycle
  // never opens room for a request in the same cycle.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign bus.mem_qvalid_o = bus.lsu_qvalid_i & ~w_full;
  assign bus.lsu_qready_o = bus.mem_qready_i & ~w_full;
  assign bus.mem_qaddr_o  = {bus.lsu_qaddr_i[31:3], 3'b000};

  assign w_push   = bus.lsu_qvalid_i & bus.mem_qready_i & ~w_full;
  // A response may only be taken if the slot is free or is being drained now.
  assign w_pready = ~w_empty & (~r_pvalid | bus.lsu_pready_i);
  assign w_pop    = bus.mem_pvalid_i & w_pready;

  assign bus.mem_pready_o = w_pready;
  assign bus.empty_o      = w_empty;
  assign bus.lsu_pvalid_o = r_pvalid;
  assign bus.lsu_ptag_o   = r_ptag;
  assign bus.lsu_pdata_o  = r_pdata;

  // Queue storage needs no reset: entries are only read when count says so.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{tag:      tag_t'(bus.lsu_qtag_i),
                         sign_ext: bus.lsu_qsigned_i,
                         offset:   bus.lsu_qaddr_i[2:0],
                         size:     bus.lsu_qsize_i};
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Bytes shifted in past byte 7 are zero, which gives the misaligned
  // "missing high bytes read as 0" behaviour for free.
  assign w_head = r_mem[r_rptr];
  assign w_sh   = bus.mem_pdata_i >> {w_head.offset, 3'b000};

  always_comb begin
    w_fill    = 1'b0;
    w_aligned = '0;
    case (w_head.size)
      2'd0: begin
        w_fill    = w_head.sign_ext & w_sh[7];
        w_aligned = {{56{w_fill}}, w_sh[7:0]};
      end
      2'd1: begin
        w_fill    = w_head.sign_ext & w_sh[15];
        w_aligned = {{48{w_fill}}, w_sh[15:0]};
      end
      2'd2: begin
        w_fill    = w_head.sign_ext & w_sh[31];
        w_aligned = {{32{w_fill}}, w_sh[31:0]};
      end
      default: w_aligned = bus.mem_pdata_i;
    endcase
  end

  // Output slot: a pop always reloads it (back-to-back results); otherwise it
  // empties once consumed and holds its contents while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pvalid <= 1'b0;
      r_ptag   <= '0;
      r_pdata  <= '0;
    end else if (w_pop) begin
      r_pvalid <= 1'b1;
      r_ptag   <= w_head.tag;
      r_pdata  <= w_aligned;
    end else if (bus.lsu_pready_i) begin
      r_pvalid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_no_resp_when_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(bus.mem_pvalid_i && w_empty)
  ) else $error("lsu_laq_fifo: memory response with no load outstanding");
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_laq_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_laq_fifo
//  Purpose  : Self-checking bench for lsu_laq_fifo. Single-load vectors from a
//             table, plus hand-written multi-cycle sequences (fill/full,
//             back-pressure, full with same-cycle pop, asynchronous reset).
//             Expected results are queued as requests are accepted and
//             compared when the result channel hands them over.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_laq_fifo;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_laq_fifo_if #(.TAG_W(5)) bus();

  lsu_laq_fifo #(.DEPTH(4), .tag_t(logic [4:0])) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  tag;
    logic [63:0] data;
  } res_t;
  res_t sb[$];

  typedef struct {
    logic        sgn;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] resp;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-by-byte reference of the aligner.
  function automatic logic [63:0] model(input logic [63:0] d, input logic [2:0] off,
                                        input logic [1:0] sz, input logic sgn);
    logic [63:0] r;
    int          nb;
    logic        fill;
    if (sz == 2'd3) return d;
    nb = 1 << sz;
    r  = '0;
    for (int i = 0; i < nb; i++)
      if (int'(off) + i < 8) r[i*8 +: 8] = d[(int'(off) + i)*8 +: 8];
    fill = sgn & r[nb*8-1];
    for (int b = 0; b < 64; b++)
      if (b >= nb*8) r[b] = fill;
    return r;
  endfunction

  // Result monitor: every handed-over result must match the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && bus.lsu_pvalid_o && bus.lsu_pready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result_tag", 64'(bus.lsu_ptag_o), 64'(e.tag));
        check("result_data", bus.lsu_pdata_o, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [4:0] t, input logic sgn, input logic [31:0] addr,
                        input logic [1:0] size, input logic [63:0] exp);
    int n = 0;
    bus.lsu_qvalid_i  = 1'b1;
    bus.lsu_qtag_i    = t;
    bus.lsu_qsigned_i = sgn;
    bus.lsu_qaddr_i   = addr;
    bus.lsu_qsize_i   = size;
    @(negedge clk);
    while (!bus.lsu_qready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.lsu_qready_o) begin
      check("req_timeout", 64'd0, 64'd1);
    end else begin
      check("mem_qaddr", 64'(bus.mem_qaddr_o), 64'({addr[31:3], 3'b000}));
      check("mem_qvalid", 64'(bus.mem_qvalid_o), 64'd1);
    end
    @(posedge clk);
    if (bus.lsu_qready_o) sb.push_back('{tag: t, data: exp});
    #1 bus.lsu_qvalid_i = 1'b0;
  endtask

  task automatic do_resp(input logic [63:0] d);
    int n = 0;
    bus.mem_pvalid_i = 1'b1;
    bus.mem_pdata_i  = d;
    @(negedge clk);
    while (!bus.mem_pready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.mem_pready_o) check("resp_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.mem_pvalid_i = 1'b0;
  endtask

  function automatic logic [63:0] dpat(input int t);
    return 64'hC0DE_5A00_0000_0000 | (64'(t) << 8) | 64'(t);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // sgn  addr          size  resp                    expected
    vecs[0] = '{1'b1, 32'h0000_1003, 2'd0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{1'b0, 32'h0000_2006, 2'd1, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0104, 2'd2, 64'h89AB_CDEF_0123_4567, 64'hFFFF_FFFF_89AB_CDEF};
    vecs[3] = '{1'b0, 32'h0000_0104, 2'd2, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_89AB_CDEF};
    vecs[4] = '{1'b1, 32'h0000_0105, 2'd3, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
    vecs[5] = '{1'b0, 32'h0000_0007, 2'd0, 64'hFE00_0000_0000_0000, 64'h0000_0000_0000_00FE};
    vecs[6] = '{1'b1, 32'h0000_000F, 2'd1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0080};
    vecs[7] = '{1'b1, 32'h0000_0016, 2'd2, 64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_FFFF};
    vecs[8] = '{1'b1, 32'h0000_0022, 2'd1, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001};
    vecs[9] = '{1'b1, 32'h0000_0030, 2'd0, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F};

    bus.lsu_qvalid_i  = 1'b0;
    bus.lsu_qtag_i    = '0;
    bus.lsu_qsigned_i = 1'b0;
    bus.lsu_qaddr_i   = '0;
    bus.lsu_qsize_i   = '0;
    bus.mem_qready_i  = 1'b1;
    bus.mem_pvalid_i  = 1'b0;
    bus.mem_pdata_i   = '0;
    bus.lsu_pready_i  = 1'b1;

    // Reset state
    idle(2);
    check("rst_empty",  64'(bus.empty_o), 64'd1);
    check("rst_pvalid", 64'(bus.lsu_pvalid_o), 64'd0);
    check("rst_ptag",   64'(bus.lsu_ptag_o), 64'd0);
    check("rst_pdata",  bus.lsu_pdata_o, 64'd0);
    check("rst_pready", 64'(bus.mem_pready_o), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Table of single loads
    for (int i = 0; i < 10; i++) begin
      do_req(5'(i + 1), vecs[i].sgn, vecs[i].addr, vecs[i].size, vecs[i].exp);
      check("busy_empty", 64'(bus.empty_o), 64'd0);
      do_resp(vecs[i].resp);
      idle(2);
      check("idle_empty", 64'(bus.empty_o), 64'd1);
    end

    // Fill to DEPTH, fifth request refused, drain in order
    for (int t = 1; t <= 4; t++) do_req(5'(t), 1'b0, 32'(t * 8), 2'd3, dpat(t));
    bus.lsu_qvalid_i = 1'b1;
    bus.lsu_qtag_i   = 5'd5;
    @(negedge clk);
    check("full_qready", 64'(bus.lsu_qready_o), 64'd0);
    check("full_qvalid", 64'(bus.mem_qvalid_o), 64'd0);
    check("full_empty",  64'(bus.empty_o), 64'd0);
    @(posedge clk);
    #1 bus.lsu_qvalid_i = 1'b0;
    for (int t = 1; t <= 4; t++) do_resp(dpat(t));
    idle(3);
    check("drain_empty", 64'(bus.empty_o), 64'd1);
    check("drain_sb",    64'(sb.size()), 64'd0);

    // Back-pressure: slot held, second response refused, then back-to-back
    bus.lsu_pready_i = 1'b0;
    do_req(5'd10, 1'b1, 32'h0000_0044, 2'd2, model(64'h1234_5678_9ABC_DEF0, 3'd4, 2'd2, 1'b1));
    do_req(5'd11, 1'b0, 32'h0000_0049, 2'd0, model(64'h0000_0000_0000_A500, 3'd1, 2'd0, 1'b0));
    do_resp(64'h1234_5678_9ABC_DEF0);
    bus.mem_pvalid_i = 1'b1;
    bus.mem_pdata_i  = 64'h0000_0000_0000_A500;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("hold_mem_pready", 64'(bus.mem_pready_o), 64'd0);
      check("hold_pvalid", 64'(bus.lsu_pvalid_o), 64'd1);
      check("hold_ptag",   64'(bus.lsu_ptag_o), 64'd10);
      check("hold_pdata",  bus.lsu_pdata_o, 64'h0000_0000_1234_5678);
      @(posedge clk);
      #1;
    end
    bus.lsu_pready_i = 1'b1;
    @(negedge clk);
    check("release_mem_pready", 64'(bus.mem_pready_o), 64'd1);
    @(posedge clk);
    #1 bus.mem_pvalid_i = 1'b0;
    @(negedge clk);
    check("b2b_pvalid", 64'(bus.lsu_pvalid_o), 64'd1);
    check("b2b_ptag",   64'(bus.lsu_ptag_o), 64'd11);
    idle(2);
    check("b2b_empty", 64'(bus.empty_o), 64'd1);

    // Full with same-cycle pop and new request: stall one cycle, then accept
    for (int t = 20; t <= 23; t++) do_req(5'(t), 1'b0, 32'(t * 8), 2'd3, dpat(t));
    bus.mem_pvalid_i  = 1'b1;
    bus.mem_pdata_i   = dpat(20);
    bus.lsu_qvalid_i  = 1'b1;
    bus.lsu_qtag_i    = 5'd24;
    bus.lsu_qsigned_i = 1'b0;
    bus.lsu_qaddr_i   = 32'h0000_0031;
    bus.lsu_qsize_i   = 2'd0;
    @(negedge clk);
    check("fullpop_mem_pready", 64'(bus.mem_pready_o), 64'd1);
    check("fullpop_qready",     64'(bus.lsu_qready_o), 64'd0);
    @(posedge clk);
    #1 bus.mem_pvalid_i = 1'b0;
    @(negedge clk);
    check("fullpop_next_qready", 64'(bus.lsu_qready_o), 64'd1);
    @(posedge clk);
    if (bus.lsu_qready_o) sb.push_back('{tag: 5'd24, data: model(dpat(24), 3'd1, 2'd0, 1'b0)});
    #1 bus.lsu_qvalid_i = 1'b0;
    for (int t = 21; t <= 24; t++) do_resp(dpat(t));
    idle(3);
    check("wrap_empty", 64'(bus.empty_o), 64'd1);
    check("wrap_sb",    64'(sb.size()), 64'd0);

    // Asynchronous reset with 3 outstanding and a held result
    bus.lsu_pready_i = 1'b0;
    for (int t = 1; t <= 4; t++) do_req(5'(t), 1'b0, 32'(t * 8), 2'd3, dpat(t));
    do_resp(dpat(1));
    check("prerst_pvalid", 64'(bus.lsu_pvalid_o), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pvalid", 64'(bus.lsu_pvalid_o), 64'd0);
    check("arst_empty",  64'(bus.empty_o), 64'd1);
    check("arst_pdata",  bus.lsu_pdata_o, 64'd0);
    sb.delete();
    bus.lsu_pready_i = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    do_req(5'd7, vecs[0].sgn, vecs[0].addr, vecs[0].size, vecs[0].exp);
    do_resp(vecs[0].resp);
    idle(3);
    check("post_rst_empty", 64'(bus.empty_o), 64'd1);
    check("final_sb",       64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
